wb_initiator: RTL
=================

// Module: wb_initiator
// PURPOSE
//  Wishbone classic single-transfer initiator: turns a valid/ready command stream into one
//  bus cycle at a time towards peripheral responders (GPIO etc.), returns read data or an
//  error on a valid/ready response stream. Used by test/loader logic that must drive the
//  peripheral bus without the CPU. One outstanding transfer; no bursts, no pipelining.
// PARAMETERS
//  AW              32   address width of command and bus
//  DW              32   data width of command, bus and response
//  TIMEOUT_CYCLES  255  max cycles STB is held without ACK (used only with WB_INIT_TIMEOUT_EN), >=1
// PORTS
//  i_wb_clk     in   1   single clock for all logic
//  i_wb_rst_n   in   1   reset, asynchronous, active-low
//  i_cmd_valid  in   1   command present
//  o_cmd_ready  out  1   command accepted when valid&ready at clock edge
//  i_cmd_we     in   1   1=write, 0=read
//  i_cmd_adr    in   AW  target address
//  i_cmd_dat    in   DW  write data (ignored for reads)
//  o_rsp_valid  out  1   response present
//  i_rsp_ready  in   1   response consumed when valid&ready at clock edge
//  o_rsp_dat    out  DW  read data; 0 for writes and errors
//  o_rsp_err    out  1   1=transfer timed out
//  o_wb_adr     out  AW  bus address
//  o_wb_dat     out  DW  bus write data
//  o_wb_we      out  1   bus write enable
//  o_wb_stb     out  1   bus strobe
//  o_wb_cyc     out  1   bus cycle, always equal to o_wb_stb
//  i_wb_rdt     in   DW  responder read data
//  i_wb_ack     in   1   responder acknowledge (responders may ack combinationally from STB)
// BEHAVIOUR
//  - Reset (async, i_wb_rst_n=0): state IDLE; o_wb_stb/o_wb_cyc/o_wb_we=0, o_wb_adr/o_wb_dat=0,
//    o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=0, timeout counter=0. Outputs clear without a clock edge.
//  - All outputs registered except o_cmd_ready = (state==IDLE) and o_wb_cyc = o_wb_stb.
//  - FSM IDLE -> BUS -> RESP -> IDLE:
//    IDLE: o_cmd_ready=1. On valid&ready: latch we/adr/dat onto o_wb_*, o_wb_stb<=1, cnt<=0, ->BUS.
//    BUS: o_wb_adr/dat/we and stb held stable. i_wb_ack=1 at edge: stb<=0, o_rsp_dat<= we ? 0 :
//      i_wb_rdt, o_rsp_err<=0, o_rsp_valid<=1, ->RESP. Else cnt<=cnt+1 (saturating).
//    RESP: o_rsp_valid/dat/err held until i_rsp_ready=1 at edge, then o_rsp_valid<=0, ->IDLE.
//  - STB is dropped on the edge that samples ACK, so STB is never high after ACK (responder
//    ack tracks STB); with a combinational-ack responder STB is high for exactly 1 cycle.
//  - Latency: accept edge E0, ACK sampled E1, o_rsp_valid high from E1; with i_rsp_ready tied 1
//    next command accepted at E3 (3 cycles/transfer minimum).
//  - No command accepted in BUS or RESP; i_cmd_* ignored there (no skid buffer).
//  - i_wb_ack in IDLE or RESP is ignored (no state change, no response).
//  - i_wb_rdt sampled only on the ACK edge of a read; write data never reflected back.
//  - Reset mid-BUS: STB drops asynchronously, transfer lost, no response issued after reset.
// CONFIGURATION
//  - WB_INIT_TIMEOUT_EN defined: in BUS, if ACK not seen and cnt==TIMEOUT_CYCLES-1 at an edge,
//    stb<=0, o_rsp_dat<=0, o_rsp_err<=1, o_rsp_valid<=1, ->RESP (STB high exactly TIMEOUT_CYCLES
//    cycles). ACK on that same edge wins: normal response, err=0.
//  - Not defined: counter logic absent, BUS waits for ACK indefinitely, o_rsp_err constant 0.
// TESTING
//  - Reset: assert i_wb_rst_n=0 mid-run -> all outputs 0 immediately, o_cmd_ready=1 after release.
//  - Write: cmd we=1 adr=0x0000_0010 dat=0x0000_0005, responder ack=stb -> stb high 1 cycle with
//    adr/dat/we stable; rsp valid, err=0, dat=0x0 one edge after ack.
//  - Read: cmd we=0 adr=0x0000_0010, responder i_wb_rdt=0x0000_00A5, ack after 3 wait cycles ->
//    stb high 4 cycles, rsp dat=0x0000_00A5, err=0.
//  - Backpressure: i_rsp_ready=0 for 5 cycles -> rsp valid/dat held, o_cmd_ready=0, stb=0; new
//    i_cmd_valid not accepted until rsp handshake completes.
//  - Timeout (WB_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=8): responder never acks -> stb high 8 cycles,
//    rsp err=1 dat=0; without macro stb stays high for 100+ cycles, no rsp.
//  - Stray ack: pulse i_wb_ack in IDLE and RESP -> no response, no state change; async reset in
//    BUS -> stb low before next edge, no rsp after release.

Source files
------------

// File: rtl/wb_initiator.sv
// wb_initiator
//   Wishbone classic single-transfer initiator. Takes one command at a time from a
//   valid/ready stream, runs one bus cycle, and returns read data (or a timeout error)
//   on a valid/ready response stream. One outstanding transfer, no bursts.
//
//   Optional feature macro: WB_INIT_TIMEOUT_EN
//     defined   : a bus cycle without ACK is abandoned after TIMEOUT_CYCLES cycles
//                 and answered with o_rsp_err=1, o_rsp_dat=0.
//     undefined : the bus cycle waits for ACK indefinitely; o_rsp_err stays 0.
//
// Ports
//   i_wb_clk, i_wb_rst_n           clock, async active-low reset
//   i_cmd_valid/o_cmd_ready        command handshake; i_cmd_we/adr/dat payload
//   o_rsp_valid/i_rsp_ready        response handshake; o_rsp_dat/o_rsp_err payload
//   o_wb_adr/dat/we/stb/cyc        Wishbone initiator outputs
//   i_wb_rdt, i_wb_ack             Wishbone responder inputs
//
// States
//   IDLE | ready for a command, bus idle
//   BUS  | strobe asserted, waiting for ACK (or timeout)
//   RESP | response presented, waiting for i_rsp_ready
module wb_initiator #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_adr,
  input  logic [DW-1:0] i_cmd_dat,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_dat,
  output logic          o_rsp_err,
  output logic [AW-1:0] o_wb_adr,
  output logic [DW-1:0] o_wb_dat,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  output logic          o_wb_cyc,
  input  logic [DW-1:0] i_wb_rdt,
  input  logic          i_wb_ack
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state;

`ifdef WB_INIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
`endif

  assign o_cmd_ready = (state == IDLE);
  assign o_wb_cyc    = o_wb_stb;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state       <= IDLE;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_dat   <= '0;
      o_rsp_err   <= 1'b0;
`ifdef WB_INIT_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            o_wb_we  <= i_cmd_we;
            o_wb_adr <= i_cmd_adr;
            o_wb_dat <= i_cmd_dat;
            o_wb_stb <= 1'b1;
`ifdef WB_INIT_TIMEOUT_EN
            cnt      <= '0;
`endif
            state    <= BUS;
          end
        end
        BUS: begin
          // ACK has priority over a timeout landing on the same edge.
          if (i_wb_ack) begin
            o_wb_stb    <= 1'b0;
            o_rsp_dat   <= o_wb_we ? '0 : i_wb_rdt;
            o_rsp_err   <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end
`ifdef WB_INIT_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            o_wb_stb    <= 1'b0;
            o_rsp_dat   <= '0;
            o_rsp_err   <= 1'b1;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
